// File: rtl/vram_arbiter_pkg.sv
// Shared encodings for the VRAM arbiter: fill sequencer states and RAM grant sources.
package vram_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDone
  } fill_state_e;

  typedef enum logic [1:0] {
    GntNone,
    GntRd,
    GntWr,
    GntFill
  } grant_e;

endpackage

// File: rtl/vram_fill_seq.sv
// Fill sequencer: walks every RAM address once with a latched value, advancing only when
// the arbiter grants it the RAM.
module vram_fill_seq
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned AddressWidth = 14,
  parameter int unsigned DataWidth    = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    fill_start,
  input  logic [DataWidth-1:0]    fill_value,
  input  logic                    fill_gnt,
  output fill_state_e             state,
  output logic [AddressWidth-1:0] fill_addr,
  output logic [DataWidth-1:0]    fill_data,
  output logic                    busy,
  output logic                    fill_done
);

  // FSM with registered busy/fill_done; fill_start is only honoured in StIdle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= StIdle;
      fill_addr <= '0;
      fill_data <= '0;
      busy      <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (fill_start) begin
            fill_data <= fill_value;
            fill_addr <= '0;
            busy      <= 1'b1;
            state     <= StFill;
          end
        end
        StFill: begin
          if (fill_gnt) begin
            fill_addr <= fill_addr + 1'b1;
            if (fill_addr == '1) begin
              fill_done <= 1'b1;
              state     <= StDone;
            end
          end
        end
        StDone: begin
          fill_done <= 1'b0;
          busy      <= 1'b0;
          state     <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares a single-port image RAM between display reads, a pixel writer and
// a fill engine. Starved writes are force-granted over reads; the lost read is flagged.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned AddressWidth = 14,
  parameter int unsigned DataWidth    = 8,
  parameter int unsigned MaxWait      = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  // Display read port
  input  logic                    rd_req,
  input  logic [AddressWidth-1:0] rd_addr,
  output logic                    rd_valid,
  output logic [DataWidth-1:0]    rd_data,
  output logic                    rd_miss,
  // Writer port
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [AddressWidth-1:0] wr_addr,
  input  logic [DataWidth-1:0]    wr_data,
  // Fill control
  input  logic                    fill_start,
  input  logic [DataWidth-1:0]    fill_value,
  output logic                    busy,
  output logic                    fill_done,
  // RAM side
  output logic                    ram_rw,
  output logic [AddressWidth-1:0] ram_addr,
  output logic [DataWidth-1:0]    ram_data_in,
  input  logic [DataWidth-1:0]    ram_data_out
);

  localparam int unsigned CntWidth = $clog2(MaxWait + 1);

  fill_state_e             state;
  logic [AddressWidth-1:0] fill_addr;
  logic [DataWidth-1:0]    fill_data;
  logic [CntWidth-1:0]     wait_cnt;
  logic                    forced;
  logic                    fill_gnt;
  grant_e                  grant;

  vram_fill_seq #(
    .AddressWidth(AddressWidth),
    .DataWidth   (DataWidth)
  ) u_fill_seq (
    .clk       (clk),
    .rstn      (rstn),
    .fill_start(fill_start),
    .fill_value(fill_value),
    .fill_gnt  (fill_gnt),
    .state     (state),
    .fill_addr (fill_addr),
    .fill_data (fill_data),
    .busy      (busy),
    .fill_done (fill_done)
  );

  // The counter is held at zero outside StIdle, so a forced write can only occur in StIdle.
  assign forced   = wr_valid && (state == StIdle) && (wait_cnt == CntWidth'(MaxWait));
  assign wr_ready = (state == StIdle) && (forced || !rd_req);
  assign fill_gnt = (grant == GntFill);
  assign rd_data  = ram_data_out;

  // Fixed-priority grant: forced write > read > fill > write.
  always_comb begin
    grant = GntNone;
    if (forced) begin
      grant = GntWr;
    end else if (rd_req) begin
      grant = GntRd;
    end else if (state == StFill) begin
      grant = GntFill;
    end else if (wr_valid && state == StIdle) begin
      grant = GntWr;
    end
  end

  // RAM port mux; an idle RAM sees a harmless read of address 0.
  always_comb begin
    ram_rw      = 1'b1;
    ram_addr    = '0;
    ram_data_in = '0;
    case (grant)
      GntRd: begin
        ram_addr = rd_addr;
      end
      GntWr: begin
        ram_rw      = 1'b0;
        ram_addr    = wr_addr;
        ram_data_in = wr_data;
      end
      GntFill: begin
        ram_rw      = 1'b0;
        ram_addr    = fill_addr;
        ram_data_in = fill_data;
      end
      default: ;
    endcase
  end

  // Starvation counter: counts stalled write cycles in StIdle, saturating at MaxWait.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt <= '0;
    end else if (state != StIdle || !wr_valid || wr_ready) begin
      wait_cnt <= '0;
    end else if (wait_cnt != CntWidth'(MaxWait)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Read response flags, aligned with the RAM's one-cycle read latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_valid <= 1'b0;
      rd_miss  <= 1'b0;
    end else begin
      rd_valid <= (grant == GntRd);
      rd_miss  <= forced && rd_req;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: two instances (wide address for port tests, 4-bit address for
// fill tests), each with a behavioural RAM; read responses go through a scoreboard queue.
module tb_vram_arbiter;

  typedef struct packed {
    logic       miss;
    logic [7:0] data;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int done_b = 0;

  rsp_t q_a[$];
  rsp_t q_b[$];

  // Instance A: AddressWidth 14
  logic        rstn_a, rd_req_a, rd_valid_a, rd_miss_a, wr_valid_a, wr_ready_a;
  logic        fill_start_a, busy_a, fill_done_a, ram_rw_a;
  logic [13:0] rd_addr_a, wr_addr_a, ram_addr_a;
  logic [7:0]  rd_data_a, wr_data_a, fill_value_a, ram_din_a, ram_dout_a;
  logic [7:0]  mem_a [16384];

  // Instance B: AddressWidth 4
  logic        rstn_b, rd_req_b, rd_valid_b, rd_miss_b, wr_valid_b, wr_ready_b;
  logic        fill_start_b, busy_b, fill_done_b, ram_rw_b;
  logic [3:0]  rd_addr_b, wr_addr_b, ram_addr_b;
  logic [7:0]  rd_data_b, wr_data_b, fill_value_b, ram_din_b, ram_dout_b;
  logic [7:0]  mem_b [16];

  int          wcount [16];
  logic [7:0]  wdata [16];
  logic        wclr;

  vram_arbiter #(.AddressWidth(14), .DataWidth(8), .MaxWait(16)) u_dut_a (
    .clk(clk), .rstn(rstn_a),
    .rd_req(rd_req_a), .rd_addr(rd_addr_a), .rd_valid(rd_valid_a), .rd_data(rd_data_a),
    .rd_miss(rd_miss_a),
    .wr_valid(wr_valid_a), .wr_ready(wr_ready_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .fill_start(fill_start_a), .fill_value(fill_value_a), .busy(busy_a),
    .fill_done(fill_done_a),
    .ram_rw(ram_rw_a), .ram_addr(ram_addr_a), .ram_data_in(ram_din_a),
    .ram_data_out(ram_dout_a)
  );

  vram_arbiter #(.AddressWidth(4), .DataWidth(8), .MaxWait(16)) u_dut_b (
    .clk(clk), .rstn(rstn_b),
    .rd_req(rd_req_b), .rd_addr(rd_addr_b), .rd_valid(rd_valid_b), .rd_data(rd_data_b),
    .rd_miss(rd_miss_b),
    .wr_valid(wr_valid_b), .wr_ready(wr_ready_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .fill_start(fill_start_b), .fill_value(fill_value_b), .busy(busy_b),
    .fill_done(fill_done_b),
    .ram_rw(ram_rw_b), .ram_addr(ram_addr_b), .ram_data_in(ram_din_b),
    .ram_data_out(ram_dout_b)
  );

  // Single-port RAMs with one-cycle registered read.
  always_ff @(posedge clk) begin
    if (ram_rw_a) ram_dout_a <= mem_a[ram_addr_a];
    else          mem_a[ram_addr_a] <= ram_din_a;
  end

  always_ff @(posedge clk) begin
    if (ram_rw_b) ram_dout_b <= mem_b[ram_addr_b];
    else          mem_b[ram_addr_b] <= ram_din_b;
  end

  function automatic rsp_t mk(input logic miss, input logic [7:0] data);
    rsp_t r;
    r.miss = miss;
    r.data = data;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever either instance presents a read response.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (fill_done_b) done_b++;
      if (rd_valid_a || rd_miss_a) begin
        if (q_a.size() == 0) begin
          chk("rdA_unexpected", 32'(rd_valid_a), 32'(0));
        end else begin
          e = q_a.pop_front();
          chk("rdA_miss", 32'(rd_miss_a), 32'(e.miss));
          chk("rdA_valid", 32'(rd_valid_a), 32'(!e.miss));
          if (!e.miss) chk("rdA_data", 32'(rd_data_a), 32'(e.data));
        end
      end
      if (rd_valid_b || rd_miss_b) begin
        if (q_b.size() == 0) begin
          chk("rdB_unexpected", 32'(rd_valid_b), 32'(0));
        end else begin
          e = q_b.pop_front();
          chk("rdB_miss", 32'(rd_miss_b), 32'(e.miss));
          chk("rdB_valid", 32'(rd_valid_b), 32'(!e.miss));
          if (!e.miss) chk("rdB_data", 32'(rd_data_b), 32'(e.data));
        end
      end
    end
  end

  // Write tracker for instance B, sampled just before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (wclr) begin
        for (int a = 0; a < 16; a++) begin
          wcount[a] = 0;
          wdata[a]  = 8'h00;
        end
      end else if (rstn_b && !ram_rw_b) begin
        wcount[ram_addr_b] = wcount[ram_addr_b] + 1;
        wdata[ram_addr_b]  = ram_din_b;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_a = 1'b0; rd_req_a = 1'b0; rd_addr_a = '0; wr_valid_a = 1'b0; wr_addr_a = '0;
    wr_data_a = '0; fill_start_a = 1'b0; fill_value_a = '0;
    rstn_b = 1'b0; rd_req_b = 1'b0; rd_addr_b = '0; wr_valid_b = 1'b0; wr_addr_b = '0;
    wr_data_b = '0; fill_start_b = 1'b0; fill_value_b = '0;
    wclr = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busyA", 32'(busy_a), 32'(0));
    chk("rst_rdvalidA", 32'(rd_valid_a), 32'(0));
    chk("rst_rdmissA", 32'(rd_miss_a), 32'(0));
    chk("rst_filldoneA", 32'(fill_done_a), 32'(0));
    chk("rst_wrreadyA", 32'(wr_ready_a), 32'(1));
    chk("rst_ramrwA", 32'(ram_rw_a), 32'(1));
    chk("rst_ramaddrA", 32'(ram_addr_a), 32'(0));
    chk("rst_ramdinA", 32'(ram_din_a), 32'(0));
    chk("rst_busyB", 32'(busy_b), 32'(0));
    @(negedge clk);
    rstn_a = 1'b1; rstn_b = 1'b1; wclr = 1'b0;

    // Plain write of 0xA3 to 0x0005
    @(negedge clk);
    wr_valid_a = 1'b1; wr_addr_a = 14'h0005; wr_data_a = 8'hA3;
    #1;
    chk("wr5_ready", 32'(wr_ready_a), 32'(1));
    chk("wr5_rw", 32'(ram_rw_a), 32'(0));
    chk("wr5_addr", 32'(ram_addr_a), 32'h5);
    chk("wr5_din", 32'(ram_din_a), 32'hA3);

    // Read 0x0005
    @(negedge clk);
    wr_valid_a = 1'b0; rd_req_a = 1'b1; rd_addr_a = 14'h0005;
    #1;
    chk("rd5_rw", 32'(ram_rw_a), 32'(1));
    chk("rd5_addr", 32'(ram_addr_a), 32'h5);
    q_a.push_back(mk(1'b0, 8'hA3));

    // Write 0x7E to 0x0010, then read it back
    @(negedge clk);
    rd_req_a = 1'b0; wr_valid_a = 1'b1; wr_addr_a = 14'h0010; wr_data_a = 8'h7E;
    #1;
    chk("wr10_ready", 32'(wr_ready_a), 32'(1));
    chk("wr10_rw", 32'(ram_rw_a), 32'(0));
    @(negedge clk);
    wr_valid_a = 1'b0; rd_req_a = 1'b1; rd_addr_a = 14'h0010;
    #1;
    chk("rd10_rw", 32'(ram_rw_a), 32'(1));
    q_a.push_back(mk(1'b0, 8'h7E));

    // Starvation: continuous reads stall the write for 16 cycles
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd_req_a = 1'b1; rd_addr_a = 14'h0005;
      wr_valid_a = 1'b1; wr_addr_a = 14'h0020; wr_data_a = 8'h55;
      #1;
      chk("starve_ready", 32'(wr_ready_a), 32'(0));
      chk("starve_rw", 32'(ram_rw_a), 32'(1));
      q_a.push_back(mk(1'b0, 8'hA3));
    end
    @(negedge clk);
    #1;
    chk("forced_ready", 32'(wr_ready_a), 32'(1));
    chk("forced_rw", 32'(ram_rw_a), 32'(0));
    chk("forced_addr", 32'(ram_addr_a), 32'h20);
    chk("forced_din", 32'(ram_din_a), 32'h55);
    q_a.push_back(mk(1'b1, 8'h00));
    @(negedge clk);
    wr_valid_a = 1'b0; rd_req_a = 1'b1; rd_addr_a = 14'h0020;
    #1;
    q_a.push_back(mk(1'b0, 8'h55));
    @(negedge clk);
    rd_req_a = 1'b0;
    #1;
    chk("idle_rw", 32'(ram_rw_a), 32'(1));
    chk("idle_addr", 32'(ram_addr_a), 32'(0));

    // Fill 0x00 with no reads; a second fill_start mid-fill is ignored
    @(negedge clk);
    fill_start_b = 1'b1; fill_value_b = 8'h00;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      fill_start_b = (i == 4);
      fill_value_b = (i == 4) ? 8'h99 : 8'h00;
      #1;
      chk("fill1_rw", 32'(ram_rw_b), 32'(0));
      chk("fill1_addr", 32'(ram_addr_b), 32'(i));
      chk("fill1_din", 32'(ram_din_b), 32'h00);
      chk("fill1_busy", 32'(busy_b), 32'(1));
    end
    @(negedge clk);
    fill_start_b = 1'b0;
    #1;
    chk("fill1_done", 32'(fill_done_b), 32'(1));
    chk("fill1_done_busy", 32'(busy_b), 32'(1));
    chk("fill1_done_rw", 32'(ram_rw_b), 32'(1));
    @(negedge clk);
    #1;
    chk("fill1_done_pulse", 32'(fill_done_b), 32'(0));
    chk("fill1_busy_after", 32'(busy_b), 32'(0));
    chk("fill1_done_count", 32'(done_b), 32'(1));
    for (int a = 0; a < 16; a++) begin
      chk("fill1_once", 32'(wcount[a]), 32'(1));
      chk("fill1_val", 32'(wdata[a]), 32'h00);
    end
    wclr = 1'b1;
    @(negedge clk);
    wclr = 1'b0;

    // Fill 0x5A with reads on alternate cycles
    @(negedge clk);
    fill_start_b = 1'b1; fill_value_b = 8'h5A;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      fill_start_b = 1'b0;
      rd_req_b = i[0];
      rd_addr_b = 4'd15;
      #1;
      if (i[0]) begin
        chk("fill2_rd_rw", 32'(ram_rw_b), 32'(1));
        q_b.push_back(mk(1'b0, 8'h00));
      end else begin
        chk("fill2_rw", 32'(ram_rw_b), 32'(0));
        chk("fill2_addr", 32'(ram_addr_b), 32'(i / 2 - 1));
        chk("fill2_din", 32'(ram_din_b), 32'h5A);
      end
    end
    @(negedge clk);
    rd_req_b = 1'b0;
    #1;
    chk("fill2_done", 32'(fill_done_b), 32'(1));
    @(negedge clk);
    #1;
    chk("fill2_busy_after", 32'(busy_b), 32'(0));
    for (int a = 0; a < 16; a++) begin
      chk("fill2_once", 32'(wcount[a]), 32'(1));
      chk("fill2_val", 32'(wdata[a]), 32'h5A);
    end

    // Simultaneous fill_start and write: write first, then fill; reset at fill_addr 7
    @(negedge clk);
    fill_start_b = 1'b1; fill_value_b = 8'h33;
    wr_valid_b = 1'b1; wr_addr_b = 4'd9; wr_data_b = 8'hC4;
    #1;
    chk("sim_wrready", 32'(wr_ready_b), 32'(1));
    chk("sim_rw", 32'(ram_rw_b), 32'(0));
    chk("sim_addr", 32'(ram_addr_b), 32'd9);
    chk("sim_din", 32'(ram_din_b), 32'hC4);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      fill_start_b = 1'b0; wr_valid_b = 1'b0;
      #1;
      chk("fill3_busy", 32'(busy_b), 32'(1));
      chk("fill3_addr", 32'(ram_addr_b), 32'(i));
      chk("fill3_din", 32'(ram_din_b), 32'h33);
    end
    #1;
    rstn_b = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy_b), 32'(0));
    chk("rst_mid_done", 32'(fill_done_b), 32'(0));
    chk("rst_mid_rw", 32'(ram_rw_b), 32'(1));
    repeat (3) @(negedge clk);
    rstn_b = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mid_nodone", 32'(done_b), 32'(2));
    chk("rst_mid_idle_busy", 32'(busy_b), 32'(0));

    // Partial fill contents: 6 refilled, 7 untouched, 9 holds the write
    @(negedge clk);
    rd_req_b = 1'b1; rd_addr_b = 4'd6;
    q_b.push_back(mk(1'b0, 8'h33));
    @(negedge clk);
    rd_addr_b = 4'd7;
    q_b.push_back(mk(1'b0, 8'h5A));
    @(negedge clk);
    rd_addr_b = 4'd9;
    q_b.push_back(mk(1'b0, 8'hC4));
    @(negedge clk);
    rd_req_b = 1'b0;

    // Fresh fill restarts at address 0
    @(negedge clk);
    fill_start_b = 1'b1; fill_value_b = 8'h11;
    @(negedge clk);
    fill_start_b = 1'b0;
    #1;
    chk("refill_addr", 32'(ram_addr_b), 32'(0));
    chk("refill_din", 32'(ram_din_b), 32'h11);
    chk("refill_busy", 32'(busy_b), 32'(1));
    repeat (15) @(negedge clk);
    @(negedge clk);
    #1;
    chk("refill_done", 32'(fill_done_b), 32'(1));

    repeat (3) @(negedge clk);
    chk("sbA_drained", 32'(q_a.size()), 32'(0));
    chk("sbB_drained", 32'(q_b.size()), 32'(0));
    chk("done_total", 32'(done_b), 32'(3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter AddressWidth, default 14, meaning the image RAM address width.
REQ-002 SHALL have parameter DataWidth, default 8, meaning the pixel width.
REQ-003 SHALL have parameter MaxWait, default 16, meaning the maximum number of stall cycles for a waiting write before it is force-granted.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rstn, input, 1, the reset: asynchronous, active-low.
REQ-006 SHALL have display read port signals: rd_req in 1, rd_addr in AddressWidth, rd_valid out 1, rd_data out DataWidth, rd_miss out 1.
REQ-007 SHALL have writer port signals: wr_valid in 1, wr_ready out 1, wr_addr in AddressWidth, wr_data in DataWidth.
REQ-008 SHALL have fill control signals: fill_start in 1, fill_value in DataWidth, busy out 1, fill_done out 1.
REQ-009 SHALL have RAM side signals: ram_rw out 1 (1 = read, 0 = write), ram_addr out AddressWidth, ram_data_in out DataWidth, ram_data_out in DataWidth.
REQ-010 SHALL assume the RAM read has 1-cycle latency: it registers data on the edge where ram_rw=1.

Function
REQ-011 SHALL make exactly one grant per cycle, chosen combinationally, in this order: forced write (starved) > read > fill > write.
REQ-012 SHALL drive RAM outputs on a read grant as ram_rw=1 and ram_addr=rd_addr.
REQ-013 SHALL drive RAM outputs on a write grant as ram_rw=0, ram_addr=wr_addr, ram_data_in=wr_data, with wr_ready=1 in that cycle.
REQ-014 SHALL drive RAM outputs on a fill grant as ram_rw=0, ram_addr=fill_addr, ram_data_in=the fill value latched at start.
REQ-015 SHALL, when no grant is made, set ram_rw=1, ram_addr=0, ram_data_in=0.
REQ-016 SHALL register rd_valid, high exactly 1 cycle after a read grant; rd_data SHALL pass ram_data_out through, valid while rd_valid=1.
REQ-017 SHALL count a write as complete when wr_valid && wr_ready; wr_ready SHALL be 0 whenever the state is not IDLE or a read/forced condition wins.
REQ-018 SHALL implement a wait counter: +1 each cycle wr_valid=1 && wr_ready=0 in IDLE; cleared on a write handshake, on wr_valid=0, or outside IDLE; saturating at MaxWait.
REQ-019 SHALL force-grant the write in the cycle the counter equals MaxWait, even if rd_req=1.
REQ-020 SHALL pulse the registered rd_miss output 1 cycle later when rd_req was 1 in that forced cycle; rd_valid SHALL stay 0 for that request.
REQ-021 SHALL implement FSM state IDLE: on fill_start=1, latch fill_value, set fill_addr=0, go to FILL.
REQ-022 SHALL implement FSM state FILL: fill_addr increments only on a fill grant; on the grant with fill_addr=2**AddressWidth-1, go to DONE.
REQ-023 SHALL implement FSM state DONE: fill_done=1 for exactly 1 cycle, then go to IDLE.
REQ-024 SHALL ignore fill_start when the state is not IDLE.
REQ-025 SHALL drive busy=1 in FILL and DONE.
REQ-026 SHALL let reads keep priority over fill, so a fill stalls during active video and the fill address never skips or wraps early.
REQ-027 SHALL, on simultaneous fill_start and wr_valid in IDLE, grant the write that cycle and enter FILL at the next edge.

Reset
REQ-028 SHALL, while rstn=0, asynchronously force state=IDLE, fill_addr=0, wait counter=0, latched fill value=0, rd_valid=0, rd_miss=0, fill_done=0.
REQ-029 SHALL give busy=0 and wr_ready as computed from IDLE with the counter at 0.
REQ-030 SHALL, on reset during FILL, abandon the fill with no fill_done pulse; RAM contents are left partially filled.

Structure
REQ-031 SHALL place in a shared package: the state encoding (IDLE, FILL, DONE) and the grant encoding (NONE, RD, WR, FILL).
REQ-032 SHALL keep AddressWidth and DataWidth as parameters, not package constants.
REQ-033 SHALL instantiate one sub-module, vram_fill_seq (the FSM plus address counter); arbitration SHALL stay at top level.
REQ-034 SHALL come with a bench that instantiates the RAM behind the arbiter.

Verification
REQ-035 SHALL cover: rd_req=1, rd_addr=0x0005, RAM[5]=0xA3 -> rd_valid=1 next cycle with rd_data=0xA3; ram_rw=1 throughout.
REQ-036 SHALL cover: wr_valid=1, wr_addr=0x0010, wr_data=0x7E, rd_req=0 -> wr_ready=1 same cycle; a later read of 0x0010 returns 0x7E.
REQ-037 SHALL cover: rd_req=1 continuously, wr_valid=1, MaxWait=16 -> wr_ready=0 for 16 cycles, forced write on the 17th, rd_miss=1 the following cycle.
REQ-038 SHALL cover: fill_start with fill_value=0x00, AddressWidth=4, no reads -> 16 consecutive writes to 0..15, fill_done pulse at cycle 17, busy low afterwards.
REQ-039 SHALL cover: fill with reads asserted on alternate cycles -> fill takes 32 cycles, every address written exactly once, all reads return valid data.
REQ-040 SHALL cover: rstn low mid-fill at fill_addr=7 -> busy=0 immediately, no fill_done, a fresh fill_start restarts at address 0.
